// File: rtl/vjtag_host_if.sv
// Host-side control and JTAG pin bundle for vjtag_host.
// The master drives requests and TDO; the slave (the host engine) drives status and TCK/TMS/TDI.
interface vjtag_host_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned LEN_W = $clog2(DATA_W + 1);

    logic              start;
    logic              is_ir;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] din;
    logic              tap_reset;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;

    modport master (
        output start, is_ir, len, din, tap_reset, tdo,
        input  busy, done, dout, tck, tms, tdi
    );

    modport slave (
        input  start, is_ir, len, din, tap_reset, tdo,
        output busy, done, dout, tck, tms, tdi
    );
endinterface

// File: rtl/vjtag_host.sv
// Bit-banged JTAG host: walks the TAP through complete IR/DR scans or a TLR/RTI resync.
// Each TCK bit is CLK_DIV clk cycles low followed by CLK_DIV clk cycles high.
module vjtag_host #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 4
) (
    input logic         clk,
    input logic         reset,
    vjtag_host_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(DATA_W + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);

    typedef enum logic [2:0] {StInit, StIdle, StHead, StShift, StTail, StFin} state_e;

    state_e            state_q, state_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIV_W-1:0]  div_q, div_d;
    // Bits remaining in the current state; the current bit is the last one when this is 1.
    logic [LEN_W-1:0]  steps_q, steps_d;
    logic [LEN_W-1:0]  len_q, len_d;
    // Outgoing data, consumed from bit 0 as the shift proceeds.
    logic [DATA_W-1:0] sh_q, sh_d;
    // One-hot pointer to the dout bit that the current shift bit fills.
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic tick;

    // End of a TCK half-period.
    assign tick = (div_q == DIV_LAST);

    // State register; reset aborts any scan and queues the INIT sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            div_q   <= '0;
            steps_q <= LEN_W'(6);
            len_q   <= '0;
            sh_q    <= '0;
            mask_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            mask_q  <= mask_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state: request acceptance, TCK phase timing and per-bit TMS/TDI selection.
    always_comb begin
        state_d = state_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        div_d   = div_q;
        steps_d = steps_q;
        len_d   = len_q;
        sh_d    = sh_q;
        mask_d  = mask_q;
        dout_d  = dout_q;

        case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                tck_d   = 1'b0;
                tms_d   = 1'b0;
                tdi_d   = 1'b0;
                busy_d  = 1'b0;
                div_d   = '0;
                if (bus.tap_reset) begin
                    // tap_reset takes priority; a simultaneous start is dropped.
                    state_d = StInit;
                    steps_d = LEN_W'(6);
                    tms_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.start) begin
                    len_d  = bus.len;
                    sh_d   = bus.din;
                    mask_d = DATA_W'(1);
                    dout_d = '0;
                    if (bus.len == '0 || bus.len > LEN_MAX) begin
                        // Nothing to shift: report completion without touching the TAP.
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StHead;
                        steps_d = bus.is_ir ? LEN_W'(4) : LEN_W'(3);
                        tms_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            default: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    tck_d = ~tck_q;
                end
                // TDO is taken on the cycle TCK rises.
                if (tick && !tck_q && state_q == StShift && bus.tdo) begin
                    dout_d = dout_q | mask_q;
                end
                // TCK falling edge: start of the next bit, the only point TMS/TDI may move.
                if (tick && tck_q) begin
                    if (steps_q > LEN_W'(1)) begin
                        steps_d = steps_q - 1'b1;
                        case (state_q)
                            StInit: tms_d = (steps_d != LEN_W'(1));
                            StHead: tms_d = (steps_d >= LEN_W'(3));
                            StShift: begin
                                tms_d  = (steps_d == LEN_W'(1));
                                tdi_d  = sh_q[1];
                                sh_d   = sh_q >> 1;
                                mask_d = mask_q << 1;
                            end
                            default: tms_d = (steps_d == LEN_W'(2));
                        endcase
                    end else begin
                        case (state_q)
                            StHead: begin
                                state_d = StShift;
                                steps_d = len_q;
                                tms_d   = (len_q == LEN_W'(1));
                                tdi_d   = sh_q[0];
                            end
                            StShift: begin
                                state_d = StTail;
                                steps_d = LEN_W'(2);
                                tms_d   = 1'b1;
                                tdi_d   = 1'b0;
                            end
                            default: begin
                                state_d = StFin;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                tms_d   = 1'b0;
                                tdi_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign bus.tck  = tck_q;
    assign bus.tms  = tms_q;
    assign bus.tdi  = tdi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_vjtag_host.sv
// Bench for vjtag_host: behavioural TAP on the pins, scan-level reference expectations.
module tb_vjtag_host;
    localparam int unsigned DW = 32;
    localparam int unsigned CD = 2;

    typedef enum int {
        TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpdDr,
        TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
    } tap_e;

    logic clk = 1'b0;
    logic reset;

    vjtag_host_if #(.DATA_W(DW)) bus ();

    vjtag_host #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // TAP model state
    tap_e        tap = TapTlr;
    logic [31:0] dr_sr = '0;
    logic [31:0] dr_val = '0;
    logic [31:0] ir_sr = '0;
    logic [31:0] ir_val = '0;
    int          dr_len = 8;
    int          ir_len = 4;

    // Pin monitors
    int          rises = 0;
    logic [63:0] tms_bits = '0;
    logic [63:0] tdi_bits = '0;
    int          done_cnt = 0;
    int          viol = 0;
    bit          mon_en = 1'b1;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TapTlr:   return m ? TapTlr   : TapRti;
            TapRti:   return m ? TapSelDr : TapRti;
            TapSelDr: return m ? TapSelIr : TapCapDr;
            TapCapDr: return m ? TapEx1Dr : TapShDr;
            TapShDr:  return m ? TapEx1Dr : TapShDr;
            TapEx1Dr: return m ? TapUpdDr : TapPauDr;
            TapPauDr: return m ? TapEx2Dr : TapPauDr;
            TapEx2Dr: return m ? TapUpdDr : TapShDr;
            TapUpdDr: return m ? TapSelDr : TapRti;
            TapSelIr: return m ? TapTlr   : TapCapIr;
            TapCapIr: return m ? TapEx1Ir : TapShIr;
            TapShIr:  return m ? TapEx1Ir : TapShIr;
            TapEx1Ir: return m ? TapUpdIr : TapPauIr;
            TapPauIr: return m ? TapEx2Ir : TapPauIr;
            TapEx2Ir: return m ? TapUpdIr : TapShIr;
            default:  return m ? TapSelDr : TapRti;
        endcase
    endfunction

    function automatic logic [31:0] lmask(input int l);
        if (l >= 32) return 32'hFFFF_FFFF;
        return 32'((64'd1 << l) - 64'd1);
    endfunction

    // TAP rising edge: state action, then transition on TMS.
    always @(posedge bus.tck) begin
        case (tap)
            TapCapDr: dr_sr = dr_val;
            TapShDr:  dr_sr = (dr_sr >> 1) | ({31'd0, bus.tdi} << (dr_len - 1));
            TapCapIr: ir_sr = 32'd1;
            TapShIr:  ir_sr = (ir_sr >> 1) | ({31'd0, bus.tdi} << (ir_len - 1));
            default: ;
        endcase
        tap = tap_next(tap, bus.tms);
    end

    // TAP falling edge: update stages and TDO drive.
    always @(negedge bus.tck) begin
        if (tap == TapUpdDr) dr_val = dr_sr;
        if (tap == TapUpdIr) ir_val = ir_sr;
        bus.tdo = (tap == TapShDr) ? dr_sr[0] : (tap == TapShIr) ? ir_sr[0] : 1'b0;
    end

    // Log TMS/TDI as seen by the TAP on each TCK rise.
    always @(posedge bus.tck) begin
        if (rises < 64) begin
            tms_bits[rises[5:0]] = bus.tms;
            tdi_bits[rises[5:0]] = bus.tdi;
        end
        rises++;
    end

    // Count clk cycles with done high.
    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    // TMS/TDI must hold still while TCK is high.
    always @(bus.tms or bus.tdi) begin
        if (mon_en && bus.tck === 1'b1) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rises = 0;
        tms_bits = '0;
        tdi_bits = '0;
        done_cnt = 0;
    endtask

    // Count busy cycles from the current negedge, then check a clean INIT sequence.
    task automatic init_check(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(cnt), 64'(6 * 2 * CD));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_tck_rises"}, 64'(rises), 64'd6);
        chk({tag, "_tms_seq"}, tms_bits, 64'h1F);
        chk({tag, "_tap_rti"}, 64'(tap), 64'(TapRti));
    endtask

    // One scan request with reference expectations derived from the scan rules.
    task automatic do_scan(input bit ir, input int l, input logic [31:0] d,
                           input logic [31:0] pre, input bit poke);
        bit          valid;
        int          nbits;
        int          head;
        int          cnt;
        int          p;
        logic [63:0] exp_tms;
        logic [31:0] exp_dout;
        logic [31:0] prev_ir;
        cnt = 0;
        while (bus.busy !== 1'b0 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        valid = (l >= 1) && (l <= 32);
        head  = ir ? 4 : 3;
        nbits = valid ? l + head + 2 : 0;
        exp_tms = '0;
        if (valid) begin
            p = 0;
            exp_tms = exp_tms | 64'd1;
            p++;
            if (ir) begin
                exp_tms = exp_tms | (64'd1 << p);
                p++;
            end
            p += 2;
            for (int k = 0; k < l; k++) begin
                if (k == l - 1) exp_tms = exp_tms | (64'd1 << p);
                p++;
            end
            exp_tms = exp_tms | (64'd1 << p);
        end
        exp_dout = !valid ? 32'd0 : ir ? 32'd1 : (pre & lmask(l));
        if (valid && !ir) begin
            dr_len = l;
            dr_val = pre & lmask(l);
        end
        if (valid && ir) ir_len = l;
        prev_ir = ir_val;

        @(negedge clk);
        clear_logs();
        bus.start = 1'b1;
        bus.is_ir = ir;
        bus.len   = 6'(l);
        bus.din   = d;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            cnt++;
            if (poke) begin
                bus.start     = (cnt == 10);
                bus.len       = 6'd4;
                bus.tap_reset = (cnt == 20);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.tap_reset = 1'b0;
        chk("busy_cycles", 64'(cnt), 64'(nbits * 2 * CD));
        chk("done_after_busy", 64'(bus.done), 64'd1);
        chk("dout", 64'(bus.dout), 64'(exp_dout));
        @(negedge clk);
        if (poke) repeat (30) @(negedge clk);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("tck_rises", 64'(rises), 64'(nbits));
        chk("tms_seq", tms_bits, exp_tms);
        if (valid) begin
            chk("tdi_shift", 64'(32'(tdi_bits >> head) & lmask(l)), 64'(d & lmask(l)));
            if (ir) chk("model_ir", 64'(ir_val), 64'(d & lmask(l)));
            else    chk("model_dr", 64'(dr_val), 64'(d & lmask(l)));
        end else begin
            chk("model_ir_kept", 64'(ir_val), 64'(prev_ir));
        end
        chk("tap_end_rti", 64'(tap), 64'(TapRti));
        chk("dout_stable", 64'(bus.dout), 64'(exp_dout));
    endtask

    initial begin
        int g;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.is_ir = 1'b0;
        bus.len = '0;
        bus.din = '0;
        bus.tap_reset = 1'b0;
        bus.tdo = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);

        chk("rst_tck", 64'(bus.tck), 64'd0);
        chk("rst_tms", 64'(bus.tms), 64'd1);
        chk("rst_tdi", 64'(bus.tdi), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dout", 64'(bus.dout), 64'd0);

        reset = 1'b0;
        init_check("init");

        do_scan(1'b0, 8, 32'h0000_00A5, 32'h0000_003C, 1'b0);
        do_scan(1'b1, 4, 32'h0000_0006, 32'h0, 1'b0);
        do_scan(1'b0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_scan(1'b0, 40, 32'h1234_5678, 32'h0, 1'b0);
        do_scan(1'b0, 32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        do_scan(1'b0, 1, 32'h1, 32'h1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_scan(1'($urandom_range(0, 1)), int'($urandom_range(1, 32)), $urandom, $urandom,
                    1'b0);
        end
        do_scan(1'b0, 8, $urandom, $urandom, 1'b1);

        // Reset in the high phase of shift bit 3 of a DR scan.
        dr_len = 8;
        dr_val = 32'h3C;
        @(negedge clk);
        clear_logs();
        bus.start = 1'b1;
        bus.is_ir = 1'b0;
        bus.len   = 6'd8;
        bus.din   = 32'hA5;
        @(negedge clk);
        bus.start = 1'b0;
        g = 0;
        while (rises < 7 && g < 500) begin
            g++;
            @(negedge clk);
        end
        chk("mid_reached_shift3", 64'(rises), 64'd7);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tck", 64'(bus.tck), 64'd0);
        chk("mid_rst_tms", 64'(bus.tms), 64'd1);
        chk("mid_rst_busy", 64'(bus.busy), 64'd1);
        chk("mid_rst_dout", 64'(bus.dout), 64'd0);
        @(negedge clk);
        clear_logs();
        mon_en = 1'b1;
        reset = 1'b0;
        init_check("mid_init");
        chk("mid_dout_after", 64'(bus.dout), 64'd0);

        // start and tap_reset together: only INIT runs.
        @(negedge clk);
        clear_logs();
        bus.start = 1'b1;
        bus.tap_reset = 1'b1;
        bus.len = 6'd8;
        @(negedge clk);
        bus.start = 1'b0;
        bus.tap_reset = 1'b0;
        init_check("tr_and_start");

        chk("tms_tdi_stable_high", 64'(viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
